// File: rtl/lake_arb_pkg.sv
// Shared types and helpers for the lake_port_arbiter bank scheduler.
// Optional feature macro used by the top: ARB_PERF_CNT_EN (per-requester grant counters).
package lake_arb_pkg;

    localparam int RSP_DEPTH  = 2;
    localparam int MAX_REQ    = 8;
    localparam int ID_W       = 3;
    // Response payload width; the top's DATA_WIDTH is expected to equal this.
    localparam int RSP_DATA_W = 16;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [RSP_DATA_W-1:0] data;
    } rsp_entry_t;

    // Returns a one-hot of the first set bit in valid, scanning ptr, ptr+1, ... mod n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [ID_W-1:0]    ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [ID_W-1:0]    idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ID_W'((int'(ptr) + k) % n);
                if (!found && valid[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lake_arb_rsp_fifo.sv
// Two-entry response FIFO holding {requester id, read data}; simultaneous push and pop allowed.
module lake_arb_rsp_fifo
    import lake_arb_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       push,
    input  rsp_entry_t push_data,
    input  logic       pop,
    output rsp_entry_t head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    rsp_entry_t entries [RSP_DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign full  = (count == 2'(RSP_DEPTH));
    assign empty = (count == 2'd0);
    assign head  = entries[rd_ptr];

endmodule

// File: rtl/lake_port_arbiter.sv
// Round-robin scheduler sharing one single-port SRAM bank among NUM_REQ requesters.
// Define ARB_PERF_CNT_EN to add the perf_grant port and saturating per-requester grant counters.
module lake_port_arbiter
    import lake_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = RSP_DATA_W,
    parameter int ADDR_WIDTH = 9
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH  = 32
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            cfg_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wen,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          mem_cen,
    output logic                          mem_wen,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  perf_grant
`endif
);

    logic               active;
    logic [MAX_REQ-1:0] elig_ext;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    rr_ptr;
    logic               rd_pend;
    logic [ID_W-1:0]    rd_id;
    logic               rd_credit;
    logic               rsp_pop;
    rsp_entry_t         fifo_head;
    rsp_entry_t         fifo_push_data;
    logic [1:0]         fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    assign active = !rst && !flush;

    // Reads may issue only while (rd_pend + fifo_count - rsp_pop) < RSP_DEPTH.
    assign rd_credit = rd_pend ? (fifo_empty || (fifo_count == 2'd1 && rsp_pop))
                               : (!fifo_full || rsp_pop);

    always_comb begin
        elig_ext = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_ext[i] = active && req_valid[i] && cfg_enable[i] && (req_wen[i] || rd_credit);
        end
    end

    assign grant     = NUM_REQ'(rr_pick(elig_ext, rr_ptr, NUM_REQ));
    assign req_ready = grant;

    always_comb begin
        win_idx   = '0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx   = ID_W'(i);
                mem_wen   = req_wen[i];
                mem_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign mem_cen = |grant;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr  <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
        end else begin
            rd_pend <= mem_cen && !mem_wen;
            rd_id   <= win_idx;
            if (mem_cen) begin
                rr_ptr <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    // mem_rdata is valid the cycle after the read, which is exactly when rd_pend is set.
    assign fifo_push_data = '{id: rd_id, data: RSP_DATA_W'(mem_rdata)};

    lake_arb_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .clear     (rst || flush),
        .push      (rd_pend),
        .push_data (fifo_push_data),
        .pop       (rsp_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = active && !fifo_empty && (fifo_head.id == ID_W'(i));
        end
    end

    assign rsp_pop  = |(rsp_valid & rsp_ready);
    assign rsp_data = DATA_WIDTH'(fifo_head.data);

`ifdef ARB_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] perf_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (perf_cnt[i] != '1)) begin
                    perf_cnt[i] <= perf_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        perf_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grant[i*CNT_WIDTH +: CNT_WIDTH] = perf_cnt[i];
        end
    end
`endif

endmodule
